// File: rtl/tx_packet_serializer_if.sv
// Radio TX word stream between the packet serializer and the radio.
//   master : drives tx_data / tx_valid / tx_last, samples tx_ready (serializer side)
//   slave  : samples tx_data / tx_valid / tx_last, drives tx_ready (radio side)
// A word transfers on a rising clock edge where tx_valid && tx_ready.
interface tx_packet_serializer_if #(
    parameter int unsigned WORD_WIDTH = 16
) ();

    logic [WORD_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/tx_packet_serializer.sv
// Packet serializer for the radio TX path.
// Captures the outgoing packet fields on reward_done, waits for the node's TDMA slot
// (or any slot when the latched timeslot is 0) while okToSend is high, then streams the
// packet as WORD_WIDTH-bit words over a valid/ready interface.
//
// Ports:
//   clk, rst          clock (rising edge) and synchronous active-high reset
//   reward_done       one-cycle pulse, r* fields valid
//   rPacketType..r*   packet fields captured on reward_done in IDLE
//   okToSend          MAC permission, level-sensitive, only looked at while waiting for a slot
//   slot_tick         one-cycle pulse advancing the TDMA slot counter
//   tx                radio word stream (master side)
//   tx_done           one-cycle pulse the cycle after the last word is accepted
//   busy              high whenever not IDLE
//   drop_cnt          saturating count of reward_done pulses ignored while busy
//
// Heartbeat packets (type 3'b000) carry HB_WORDS words, all others FULL_WORDS.
// All outputs are registered; reset wins over every other event.
module tx_packet_serializer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned NUM_SLOTS  = 64,
    parameter int unsigned HB_WORDS   = 6,
    parameter int unsigned FULL_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  reward_done,
    input  logic [2:0]            rPacketType,
    input  logic [5:0]            rTimeslot,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,

    input  logic                  okToSend,
    input  logic                  slot_tick,

    tx_packet_serializer_if.master tx,

    output logic                  tx_done,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int unsigned SlotW = $clog2(NUM_SLOTS);
    localparam int unsigned IdxW  = $clog2(FULL_WORDS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitSlot,
        StSend,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q,     state_d;
    logic [SlotW-1:0]      slot_cnt_q,  slot_cnt_d;
    logic [IdxW-1:0]       word_idx_q,  word_idx_d;

    logic [WORD_WIDTH-1:0] tx_data_q,   tx_data_d;
    logic                  tx_valid_q,  tx_valid_d;
    logic                  tx_last_q,   tx_last_d;
    logic                  tx_done_q,   tx_done_d;
    logic                  busy_q,      busy_d;
    logic [7:0]            drop_cnt_q,  drop_cnt_d;

    // Captured packet fields
    logic [2:0]            type_q,      type_d;
    logic [5:0]            tsl_q,       tsl_d;
    logic [WORD_WIDTH-1:0] src_q,       src_d;
    logic [WORD_WIDTH-1:0] dst_q,       dst_d;
    logic [WORD_WIDTH-1:0] src_hops_q,  src_hops_d;
    logic [WORD_WIDTH-1:0] qval_q,      qval_d;
    logic [WORD_WIDTH-1:0] energy_q,    energy_d;
    logic [WORD_WIDTH-1:0] ch_q,        ch_d;
    logic [WORD_WIDTH-1:0] ch_hops_q,   ch_hops_d;

    // ------------------------------------------------------------------
    // Word selection
    // ------------------------------------------------------------------
    logic [IdxW-1:0]       pkt_len;
    logic [IdxW-1:0]       sel_idx;
    logic [WORD_WIDTH-1:0] word_sel;
    logic                  transfer;
    logic                  slot_match;

    assign pkt_len = (type_q == 3'b000) ? IdxW'(HB_WORDS) : IdxW'(FULL_WORDS);

    // While sending, prefetch the word after the current one so it can be loaded on the
    // transfer edge without a bubble; otherwise select w0 for the start of a packet.
    assign sel_idx = (state_q == StSend) ? (word_idx_q + IdxW'(1)) : '0;

    always_comb begin
        word_sel = '0;
        case (sel_idx)
            IdxW'(0): word_sel = {type_q, tsl_q, {(WORD_WIDTH - 9){1'b0}}};
            IdxW'(1): word_sel = src_q;
            IdxW'(2): word_sel = dst_q;
            IdxW'(3): word_sel = src_hops_q;
            IdxW'(4): word_sel = qval_q;
            IdxW'(5): word_sel = energy_q;
            IdxW'(6): word_sel = ch_q;
            IdxW'(7): word_sel = ch_hops_q;
            default:  word_sel = '0;
        endcase
    end

    assign transfer = tx_valid_q && tx.tx_ready;

    // Compared against the counter value of this cycle, ahead of any slot_tick update.
    assign slot_match = (tsl_q == '0) || (slot_cnt_q == SlotW'(tsl_q));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        word_idx_d = word_idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        tx_done_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;

        type_d     = type_q;
        tsl_d      = tsl_q;
        src_d      = src_q;
        dst_d      = dst_q;
        src_hops_d = src_hops_q;
        qval_d     = qval_q;
        energy_d   = energy_q;
        ch_d       = ch_q;
        ch_hops_d  = ch_hops_q;

        if (slot_tick) begin
            slot_cnt_d = (slot_cnt_q == SlotW'(NUM_SLOTS - 1)) ? '0 : slot_cnt_q + SlotW'(1);
        end

        // Any request outside IDLE (including the DONE->IDLE cycle) is dropped.
        if (reward_done && (state_q != StIdle) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (reward_done) begin
                    type_d     = rPacketType;
                    tsl_d      = rTimeslot;
                    src_d      = rSourceID;
                    dst_d      = rDestinationID;
                    src_hops_d = rSourceHops;
                    qval_d     = rQValue;
                    energy_d   = rEnergyLeft;
                    ch_d       = rChosenCH;
                    ch_hops_d  = rHopsFromCH;
                    state_d    = StWaitSlot;
                end
            end

            StWaitSlot: begin
                if (okToSend && slot_match) begin
                    state_d    = StSend;
                    word_idx_d = '0;
                    tx_data_d  = word_sel;
                    tx_valid_d = 1'b1;
                    tx_last_d  = (pkt_len == IdxW'(1));
                end
            end

            StSend: begin
                // okToSend is deliberately ignored here: a started packet always completes.
                if (transfer) begin
                    if (tx_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        word_idx_d = '0;
                        tx_done_d  = 1'b1;
                        state_d    = StDone;
                    end else begin
                        word_idx_d = word_idx_q + IdxW'(1);
                        tx_data_d  = word_sel;
                        tx_last_d  = ((word_idx_q + IdxW'(2)) == pkt_len);
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            slot_cnt_q <= '0;
            word_idx_q <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            drop_cnt_q <= '0;
            type_q     <= '0;
            tsl_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            src_hops_q <= '0;
            qval_q     <= '0;
            energy_q   <= '0;
            ch_q       <= '0;
            ch_hops_q  <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            word_idx_q <= word_idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
            drop_cnt_q <= drop_cnt_d;
            type_q     <= type_d;
            tsl_q      <= tsl_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            src_hops_q <= src_hops_d;
            qval_q     <= qval_d;
            energy_q   <= energy_d;
            ch_q       <= ch_d;
            ch_hops_q  <= ch_hops_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_last  = tx_last_q;
    assign tx_done     = tx_done_q;
    assign busy        = busy_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_tx_packet_serializer.sv
// Bench for tx_packet_serializer: directed scenarios plus a randomized run, all checked
// against a transaction-level model (expected word queue, phase, slot and drop counters).
module tb_tx_packet_serializer;

    localparam int PIdle = 0;
    localparam int PWait = 1;
    localparam int PSend = 2;
    localparam int PDone = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        reward_done;
    logic [2:0]  rPacketType;
    logic [5:0]  rTimeslot;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue;
    logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
    logic        okToSend;
    logic        slot_tick;
    logic        tx_done;
    logic        busy;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    tx_packet_serializer_if #(.WORD_WIDTH(16)) tx_if ();

    tx_packet_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .reward_done    (reward_done),
        .rPacketType    (rPacketType),
        .rTimeslot      (rTimeslot),
        .rSourceID      (rSourceID),
        .rDestinationID (rDestinationID),
        .rSourceHops    (rSourceHops),
        .rQValue        (rQValue),
        .rEnergyLeft    (rEnergyLeft),
        .rChosenCH      (rChosenCH),
        .rHopsFromCH    (rHopsFromCH),
        .okToSend       (okToSend),
        .slot_tick      (slot_tick),
        .tx             (tx_if.master),
        .tx_done        (tx_done),
        .busy           (busy),
        .drop_cnt       (drop_cnt)
    );

    // Reference model
    int          m_phase;
    int unsigned m_slot;
    int unsigned m_drop;
    int unsigned m_tsl;
    logic [15:0] m_q[$];      // words of the current packet still to be sent
    logic [15:0] m_obs[$];    // words actually accepted from the DUT
    logic [15:0] exp_pkt[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic build_packet();
        m_q.delete();
        m_q.push_back(16'(rPacketType) * 16'd8192 + 16'(rTimeslot) * 16'd128);
        m_q.push_back(rSourceID);
        m_q.push_back(rDestinationID);
        m_q.push_back(rSourceHops);
        m_q.push_back(rQValue);
        m_q.push_back(rEnergyLeft);
        if (rPacketType != 3'b000) begin
            m_q.push_back(rChosenCH);
            m_q.push_back(rHopsFromCH);
        end
    endtask

    // One clock: predict from the inputs applied now, advance, then compare outputs.
    task automatic cycle();
        int          nxt;
        bit          acc;
        logic [15:0] d;
        nxt = m_phase;
        acc = tx_if.tx_valid && tx_if.tx_ready;
        d   = tx_if.tx_data;
        if (rst) begin
            nxt    = PIdle;
            m_slot = 0;
            m_drop = 0;
            m_q.delete();
        end else begin
            case (m_phase)
                PIdle: if (reward_done) begin
                    build_packet();
                    m_tsl = rTimeslot;
                    nxt   = PWait;
                end
                PWait: if (okToSend && (m_tsl == 0 || m_slot == m_tsl)) nxt = PSend;
                PSend: if (tx_if.tx_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) nxt = PDone;
                end
                default: nxt = PIdle;
            endcase
            if (reward_done && m_phase != PIdle && m_drop < 255) m_drop++;
            if (slot_tick) m_slot = (m_slot + 1) % 64;
        end
        @(posedge clk);
        #1;
        if (acc && !rst) m_obs.push_back(d);
        m_phase = nxt;
        check_eq("busy", busy, m_phase != PIdle);
        check_eq("tx_valid", tx_if.tx_valid, m_phase == PSend);
        check_eq("tx_done", tx_done, m_phase == PDone);
        check_eq("drop_cnt", drop_cnt, m_drop);
        check_eq("slot_cnt", dut.slot_cnt_q, m_slot);
        if (m_phase == PSend) begin
            check_eq("tx_data", tx_if.tx_data, m_q[0]);
            check_eq("tx_last", tx_if.tx_last, m_q.size() == 1);
        end
    endtask

    task automatic fire();
        reward_done = 1'b1;
        cycle();
        reward_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] typ, input logic [5:0] tsl, input logic [15:0] src);
        rPacketType    = typ;
        rTimeslot      = tsl;
        rSourceID      = src;
        rDestinationID = 16'($urandom);
        rSourceHops    = 16'($urandom);
        rQValue        = 16'($urandom);
        rEnergyLeft    = 16'($urandom);
        rChosenCH      = 16'($urandom);
        rHopsFromCH    = 16'($urandom);
    endtask

    // Bounded run until the model reaches a phase; optional 1,0,0 backpressure and ticks.
    task automatic run_until(input int target, input int budget, input bit bp, input bit ticks);
        int i;
        i = 0;
        while (m_phase != target && i < budget) begin
            tx_if.tx_ready = bp ? (i % 3 == 0) : 1'b1;
            slot_tick      = ticks;
            cycle();
            i++;
        end
        slot_tick      = 1'b0;
        tx_if.tx_ready = 1'b1;
        check_eq("reach_phase", m_phase, target);
    endtask

    initial begin
        int k;
        rst = 1'b1; reward_done = 1'b0; okToSend = 1'b0; slot_tick = 1'b0;
        tx_if.tx_ready = 1'b0;
        set_fields(3'b000, 6'd0, 16'd0);
        m_phase = PIdle; m_slot = 0; m_drop = 0; m_tsl = 0;
        do_reset();
        check_eq("rst_tx_data", tx_if.tx_data, 16'h0000);
        check_eq("rst_tx_last", tx_if.tx_last, 1'b0);

        // T1 heartbeat, minimum latency
        okToSend = 1'b1; tx_if.tx_ready = 1'b1;
        set_fields(3'b000, 6'd0, 16'h000C);
        m_obs.delete();
        fire();
        k = 0;
        while (!tx_if.tx_valid && k < 10) begin cycle(); k++; end
        check_eq("t1_latency", k + 1, 2);
        run_until(PIdle, 50, 1'b0, 1'b0);
        check_eq("t1_count", m_obs.size(), 6);
        check_eq("t1_w0", m_obs[0], 16'h0000);
        check_eq("t1_w1", m_obs[1], 16'h000C);

        // T2 slot wait
        do_reset();
        slot_tick = 1'b1; cycle(); cycle(); slot_tick = 1'b0;
        set_fields(3'b010, 6'd5, 16'h1234);
        m_obs.delete();
        fire();
        slot_tick = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        slot_tick = 1'b0;
        run_until(PIdle, 50, 1'b0, 1'b0);
        check_eq("t2_count", m_obs.size(), 8);
        check_eq("t2_w0", m_obs[0], 16'h4280);

        // T3 backpressure
        set_fields(3'b101, 6'd0, 16'hBEEF);
        m_obs.delete();
        fire();
        exp_pkt = m_q;
        run_until(PIdle, 100, 1'b1, 1'b0);
        check_eq("t3_count", m_obs.size(), 8);
        for (int i = 0; i < 8; i++) check_eq("t3_word", m_obs[i], exp_pkt[i]);

        // T4 drop while sending, drop on the DONE cycle, then saturation
        set_fields(3'b001, 6'd0, 16'h1111);
        m_obs.delete();
        fire();
        run_until(PSend, 20, 1'b0, 1'b0);
        rSourceID = 16'h2222;
        fire();
        check_eq("t4_drop1", drop_cnt, 8'd1);
        run_until(PDone, 50, 1'b0, 1'b0);
        check_eq("t4_src", m_obs[1], 16'h1111);
        fire();
        check_eq("t4_drop_done", drop_cnt, 8'd2);
        check_eq("t4_idle_after_done", busy, 1'b0);
        okToSend = 1'b0;
        set_fields(3'b011, 6'd7, 16'h3333);
        fire();
        for (int i = 0; i < 300; i++) fire();
        check_eq("t4_sat", drop_cnt, 8'hFF);
        okToSend = 1'b1;
        run_until(PIdle, 300, 1'b0, 1'b1);

        // T5 reset mid-packet
        slot_tick = 1'b1; cycle(); cycle(); cycle(); slot_tick = 1'b0;
        set_fields(3'b010, 6'd0, 16'h5555);
        m_obs.delete();
        fire();
        k = 0;
        while (m_obs.size() < 3 && k < 20) begin cycle(); k++; end
        check_eq("t5_three_words", m_obs.size(), 3);
        do_reset();
        check_eq("t5_valid", tx_if.tx_valid, 1'b0);
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_slot", dut.slot_cnt_q, 0);
        for (int i = 0; i < 4; i++) cycle();

        // T6 slot wrap and last slot
        slot_tick = 1'b1;
        for (int i = 0; i < 64; i++) cycle();
        slot_tick = 1'b0;
        check_eq("t6_wrap", dut.slot_cnt_q, 0);
        set_fields(3'b000, 6'd63, 16'h0063);
        m_obs.delete();
        fire();
        run_until(PIdle, 200, 1'b0, 1'b1);
        check_eq("t6_count", m_obs.size(), 6);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(599) == 0);
            reward_done = ($urandom_range(7) == 0);
            if (reward_done) begin
                set_fields(($urandom_range(2) == 0) ? 3'b000 : 3'($urandom_range(7)),
                           ($urandom_range(1) == 0) ? 6'd0 : 6'($urandom_range(63)),
                           16'($urandom));
            end
            okToSend       = ($urandom_range(3) != 0);
            slot_tick      = ($urandom_range(3) == 0);
            tx_if.tx_ready = ($urandom_range(2) != 0);
            cycle();
        end
        rst = 1'b0; reward_done = 1'b0; slot_tick = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
